ahb5_sram_subordinate: RTL and testbench
========================================

# ahb5_sram_subordinate

AHB5 subordinate (slave) backed by an internal word-addressed SRAM model, with programmable wait states and AHB5 two-cycle ERROR responses. It is the responder end of the AHB5 master VIP, and the default DUT that the ahb5 test environment drives through `ahb5_interface`. It accepts pipelined single and burst transfers of byte, halfword and word size.

## Interface

Parameters:
- `ADDR_W`, 32, HADDR width.
- `DATA_W`, 32, HWDATA/HRDATA width. Fixed at 32 in this revision.
- `MEM_DEPTH`, 256, number of 32-bit words. Valid byte addresses are 0 to 4*MEM_DEPTH-1.
- `WAIT_STATES`, 0, number of HREADYOUT=0 cycles inserted before every OKAY completion (0–15).

Ports:
- `Hclk` in 1: clock. All logic is on the rising edge.
- `HReset` in 1: synchronous, active-high reset.
- `HSEL` in 1: subordinate select.
- `HADDR` in ADDR_W: transfer address.
- `HTRANS` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HWRITE` in 1: 1=write, 0=read.
- `HSIZE` in 3: 0=byte, 1=half, 2=word. Values >2 are an error.
- `HBURST` in 3: accepted and ignored. Each beat is decoded independently.
- `HWDATA` in DATA_W: write data, valid in the data phase.
- `HREADY` in 1: bus-level ready from the interconnect.
- `HREADYOUT` out 1: this subordinate's ready.
- `HRESP` out 1: 0=OKAY, 1=ERROR.
- `HRDATA` out DATA_W: read data.

## Operation

- **Address phase accept:** HSEL & HREADY & HTRANS[1] sampled at a rising edge.
  - Registers addr_q, write_q and size_q.
  - Runs the error check.
- **Error conditions:**
  - addr[ADDR_W-1:2] >= MEM_DEPTH.
  - HSIZE > 2.
  - Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
- **IDLE or BUSY with HSEL & HREADY:** zero-wait OKAY. No state change and no memory access.
- **Byte lanes:** little-endian.
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- **Writes:** commit only the enabled lanes of HWDATA.
- **Reads:** return the full word mem[addr_q[..:2]] regardless of HSIZE.
- **FSM states:**
  - `IDLE`: no pending data phase. HREADYOUT=1, HRESP=0.
  - `DATA`: wait counter loaded with WAIT_STATES on accept.
    - HREADYOUT = (cnt==0).
    - cnt decrements each cycle while nonzero.
  - `ERR1`: HREADYOUT=0, HRESP=1.
  - `ERR2`: HREADYOUT=1, HRESP=1.
- **Transitions:**
  - An accepted transfer with no error goes to `DATA`. An accepted transfer with an error goes to `ERR1`. Wait states are skipped for errors.
  - `ERR1` always goes to `ERR2`.
  - From `DATA` with cnt==0, or from `ERR2`:
    - a new accept goes to `DATA` or `ERR1`;
    - otherwise go to `IDLE`.
- **Pipelining:** a new address phase is sampled in the same cycle a previous data phase completes (HREADY=1).
  - No bubble between back-to-back transfers.
  - The master may drive IDLE during `ERR2` to cancel. This is handled by normal decoding.
- **Memory contents:** not reset; the array contains X until written.

## Timing

- **Reset values (cycle after HReset=1):**
  - State `IDLE`, cnt=0.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
- **Reset mid-operation:** the pending data phase is abandoned, and a pending write is not committed.
- **Write commit:** occurs at the rising edge that ends the data phase, i.e. with HREADYOUT=1 in `DATA`, using HWDATA sampled at that edge.
- **HRDATA:**
  - Driven from mem[addr_q] whenever state=`DATA` and write_q=0; 0 otherwise.
  - Valid when HREADYOUT=1.
- **Read-after-write to the same address, back to back:** returns the new data. The write commits on the edge that starts the read's data phase.
- **Latency:**
  - OKAY completes WAIT_STATES+1 cycles after the address-phase edge.
  - ERROR completes 2 cycles after it.
- **HSEL=0 while idle:** HREADYOUT=1. An HSEL drop during `DATA` or `ERRx` does not abort the current data phase.

## Structure

- Add to `ahb5_pkg`:
  - `htrans_e` (IDLE, BUSY, NONSEQ, SEQ).
  - `hsize_e` (BYTE, HALF, WORD).
  - `sub_state_e` (IDLE, DATA, ERR1, ERR2).
  - Constant `HRESP_OKAY/ERROR`.
- One sub-module, `ahb5_sub_mem`:
  - MEM_DEPTH×32 array.
  - 4-bit byte-enable write port.
  - Asynchronous read port.
- Decode, error check, FSM and wait counter live in `ahb5_sram_subordinate`.

## Test plan

Defaults are WAIT_STATES=0 and MEM_DEPTH=256 unless stated.

1. NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ word read @0x10 back to back -> HRDATA=0xDEADBEEF, HRESP=0, no HREADYOUT low cycles.
2. Byte write @0x13 with HWDATA=0xAA000000, then word read @0x10 -> 0xAAADBEEF. Half write @0x12 with HWDATA=0x12340000, then read -> 0x1234BEEF.
3. WAIT_STATES=2, read @0x10 -> HREADYOUT=0 for exactly 2 cycles, then 1 with valid data. A following SEQ read sampled on the completing edge gets its own 2 waits.
4. Word read @0x400 (word 256) -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
5. Invalid transfers:
   - Half write @0x11 -> ERROR, memory @0x10 unchanged.
   - HSIZE=3 -> ERROR.
   - IDLE/BUSY with HSEL=1 -> HREADYOUT stays 1, HRESP=0, memory unchanged.
6. WAIT_STATES=3, word write 0x55 @0x20, HReset=1 during the second wait cycle -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0. A read @0x20 after 0x11223344 was written there before the write returns 0x11223344.

Source files
------------

// File: rtl/ahb5_pkg.sv
// Shared AHB5 encodings for the SRAM subordinate and its memory.
package ahb5_pkg;

   // Transfer type on HTRANS
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   // Transfer size on HSIZE; anything above WORD is rejected
   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   // Subordinate data-phase state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } sub_state_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Width of the wait-state counter (0..15 waits)
   localparam int WAIT_W = 4;

   // Little-endian byte lanes touched by a transfer of the given size
   function automatic logic [3:0] byte_lanes(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
      logic [3:0] lanes;
      case (size)
         HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
         HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:    lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

   // Alignment rule: halfwords on even bytes, words on 4-byte boundaries
   function automatic logic is_misaligned(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
      logic bad;
      case (size)
         HSIZE_HALF: bad = addr_lo[0];
         HSIZE_WORD: bad = |addr_lo;
         default:    bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ahb5_sub_mem.sv
// Word-organised SRAM model: byte-enable synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb5_sub_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int AW        = 8
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [0:MEM_DEPTH-1];

   // Commit only the enabled byte lanes of the write word
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
               r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb5_sram_subordinate.sv
// AHB5 subordinate in front of an internal SRAM. Decodes each beat on its
// own (HBURST is ignored), inserts WAIT_STATES before every OKAY completion
// and answers bad transfers with the two-cycle ERROR response.
//
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] are
// high at a rising edge and the subordinate is free to start a data phase
// (IDLE, DATA with no waits left, or ERR2). A data phase ends at the edge
// where HREADYOUT=1; write data is taken from HWDATA on that edge and read
// data on HRDATA is valid while HREADYOUT=1.
module ahb5_sram_subordinate
   import ahb5_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic              Hclk,
   input  logic              HReset,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [DATA_W-1:0] HRDATA,
   output logic [1:0]        o_dbg_state
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(MEM_DEPTH);
   localparam logic [WAIT_W-1:0] LP_WS    = WAIT_W'(WAIT_STATES);

   sub_state_e        r_state;
   sub_state_e        w_state_nxt;
   logic [WAIT_W-1:0] r_cnt;
   logic [WAIT_W-1:0] w_cnt_nxt;
   logic [AW-1:0]     r_addr;
   logic              r_write;
   logic [3:0]        r_lanes;

   logic              w_accept;
   logic              w_err;
   logic              w_out_of_range;
   logic              w_bad_size;
   logic              w_misaligned;
   logic              w_can_accept;
   logic              w_launch;
   logic              w_hreadyout;
   logic              w_hresp;
   logic              w_mem_we;
   logic [31:0]       w_rdata;
   logic              w_unused_hburst;

   // Burst type carries no information for a per-beat decoder
   assign w_unused_hburst = ^HBURST;

   // Address-phase decode and error classification
   assign w_accept       = HSEL & HREADY & HTRANS[1];
   assign w_out_of_range = {2'b00, HADDR[ADDR_W-1:2]} >= LP_DEPTH;
   assign w_bad_size     = HSIZE > 3'd2;
   assign w_misaligned   = is_misaligned(HSIZE, HADDR[1:0]);
   assign w_err          = w_out_of_range | w_bad_size | w_misaligned;

   // Next state, wait counter and response outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hreadyout  = 1'b1;
      w_hresp      = HRESP_OKAY;
      w_can_accept = 1'b0;
      w_launch     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_can_accept = 1'b1;
         end
         ST_DATA: begin
            w_hreadyout = (r_cnt == '0);
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_can_accept = 1'b1;
            end
         end
         ST_ERR1: begin
            w_hreadyout = 1'b0;
            w_hresp     = HRESP_ERROR;
            w_state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            w_hresp      = HRESP_ERROR;
            w_can_accept = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Whenever the previous data phase is finishing, the next address
      // phase decides where we go; errors skip the wait states entirely.
      w_launch = w_can_accept & w_accept;
      if (w_can_accept) begin
         if (w_accept) begin
            w_state_nxt = w_err ? ST_ERR1 : ST_DATA;
            w_cnt_nxt   = w_err ? '0 : LP_WS;
         end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      end
   end

   // State register and address-phase capture
   always_ff @(posedge Hclk) begin
      if (HReset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_lanes <= 4'b0000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_launch) begin
            r_addr  <= HADDR[AW+1:2];
            r_write <= HWRITE;
            r_lanes <= byte_lanes(HSIZE, HADDR[1:0]);
         end
      end
   end

   // A write lands on the edge that ends its data phase; a reset on that
   // same edge abandons it.
   assign w_mem_we = (r_state == ST_DATA) & (r_cnt == '0) & r_write & ~HReset;

   ahb5_sub_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_mem (
      .i_clk   (Hclk),
      .i_we    (w_mem_we),
      .i_be    (r_lanes),
      .i_waddr (r_addr),
      .i_wdata (HWDATA[31:0]),
      .i_raddr (r_addr),
      .o_rdata (w_rdata)
   );

   assign HREADYOUT   = w_hreadyout;
   assign HRESP       = w_hresp;
   assign HRDATA      = ((r_state == ST_DATA) && !r_write) ? w_rdata : '0;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb5_sram_subordinate.sv
// Bench for ahb5_sram_subordinate: three instances (0, 2 and 3 wait states)
// driven by a pipelined master task and checked against a byte-level model.
module tb_ahb5_sram_subordinate;
   import ahb5_pkg::*;

   typedef struct {
      logic [1:0]  trans;
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } tr_t;

   logic hclk = 1'b0;
   always #5 hclk = ~hclk;

   logic        hreset [3];
   logic        hsel   [3];
   logic [31:0] haddr  [3];
   logic [1:0]  htrans [3];
   logic        hwrite [3];
   logic [2:0]  hsize  [3];
   logic [2:0]  hburst [3];
   logic [31:0] hwdata [3];
   logic        hready_o [3];
   logic        hresp    [3];
   logic [31:0] hrdata   [3];
   logic [1:0]  dbg      [3];

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mdl [3][1024];
   tr_t tq[$];

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         ahb5_sram_subordinate #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_DEPTH   (256),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
         ) u_dut (
            .Hclk        (hclk),
            .HReset      (hreset[g]),
            .HSEL        (hsel[g]),
            .HADDR       (haddr[g]),
            .HTRANS      (htrans[g]),
            .HWRITE      (hwrite[g]),
            .HSIZE       (hsize[g]),
            .HBURST      (hburst[g]),
            .HWDATA      (hwdata[g]),
            .HREADY      (hready_o[g]),
            .HREADYOUT   (hready_o[g]),
            .HRESP       (hresp[g]),
            .HRDATA      (hrdata[g]),
            .o_dbg_state (dbg[g])
         );
      end
   endgenerate

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   function automatic tr_t mk(input logic [1:0] tr, input logic wr,
                              input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] d);
      tr_t t;
      t.trans = tr; t.write = wr; t.addr = a; t.size = sz; t.wdata = d;
      return t;
   endfunction

   // Reference rules: in range, legal size, naturally aligned
   function automatic bit is_err(input tr_t t);
      if (t.addr >= 32'd1024) return 1'b1;
      if (t.size > 3'd2) return 1'b1;
      return (t.addr % (32'd1 << t.size)) != 0;
   endfunction

   function automatic logic [31:0] mword(input int k, input logic [31:0] a);
      int base;
      base = int'(a) & ~3;
      return {mdl[k][base+3], mdl[k][base+2], mdl[k][base+1], mdl[k][base]};
   endfunction

   task automatic mwrite(input int k, input tr_t t);
      int n, base, a;
      n    = 1 << t.size;
      base = int'(t.addr) - (int'(t.addr) % n);
      for (int i = 0; i < n; i++) begin
         a = base + i;
         mdl[k][a] = t.wdata[8*(a%4) +: 8];
      end
   endtask

   function automatic string tg(input int k, input string what, input logic [31:0] a);
      return $sformatf("u%0d %s @%08h", k, what, a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic drive_idle(input int k);
      hsel[k] = 1'b0; htrans[k] = 2'd0; hwrite[k] = 1'b0;
      haddr[k] = 32'h0; hsize[k] = 3'd0; hburst[k] = 3'd0;
   endtask

   task automatic drive_addr(input int k, input tr_t t);
      hsel[k] = 1'b1; htrans[k] = t.trans; hwrite[k] = t.write;
      haddr[k] = t.addr; hsize[k] = t.size;
      hburst[k] = 3'($urandom_range(0, 7));
   endtask

   // Pipelined master: runs everything queued in tq on instance k.
   // Entered and left at #1 after a rising edge with the bus idle.
   task automatic run(input int k);
      tr_t cur, adr;
      bit hc, ha, rdy, act, er;
      int w, guard, exp_w;
      logic [31:0] exp_rd;
      hc = 0; ha = 0; w = 0; guard = 0;
      cur = mk(2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
      adr = cur;
      if (tq.size() > 0) begin adr = tq.pop_front(); ha = 1; drive_addr(k, adr); end
      while ((hc || ha) && guard < 2000) begin
         guard++;
         rdy = hready_o[k];
         if (hc) begin
            act   = cur.trans[1];
            er    = act && is_err(cur);
            exp_w = !act ? 0 : (er ? 1 : ws_of(k));
            chk(tg(k, "hreadyout", cur.addr), 32'(rdy), 32'(w >= exp_w));
            chk(tg(k, "hresp", cur.addr), 32'(hresp[k]), 32'(er));
            if (rdy) begin
               exp_rd = (act && !er && !cur.write) ? mword(k, cur.addr) : 32'h0;
               chk(tg(k, "hrdata", cur.addr), hrdata[k], exp_rd);
               if (act && !er && cur.write) mwrite(k, cur);
            end else begin
               w++;
            end
         end
         @(posedge hclk); #1;
         if (rdy) begin
            hc = ha; cur = adr; w = 0;
            if (hc) hwdata[k] = cur.write ? cur.wdata : $urandom();
            if (tq.size() > 0) begin
               adr = tq.pop_front(); ha = 1; drive_addr(k, adr);
            end else begin
               ha = 0; drive_idle(k);
            end
         end
      end
      chk(tg(k, "cycle budget", cur.addr), 32'(guard < 2000), 32'd1);
      chk(tg(k, "idle hreadyout", cur.addr), 32'(hready_o[k]), 32'd1);
      chk(tg(k, "idle hresp", cur.addr), 32'(hresp[k]), 32'd0);
   endtask

   task automatic rand_seq(input int n);
      int r;
      logic [1:0] tr;
      logic [2:0] sz;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         r  = $urandom_range(0, 99);
         tr = (r < 8) ? 2'd0 : ((r < 12) ? 2'd1 : ((r < 55) ? 2'd2 : 2'd3));
         sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a  = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                          : 32'($urandom_range(0, 63));
         tq.push_back(mk(tr, 1'($urandom_range(0, 1)), a, sz, $urandom()));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         hreset[k] = 1'b1; drive_idle(k); hwdata[k] = 32'h0;
      end
      repeat (3) @(posedge hclk);
      #1;
      // Reset values
      for (int k = 0; k < 3; k++) begin
         chk(tg(k, "rst hreadyout", 0), 32'(hready_o[k]), 32'd1);
         chk(tg(k, "rst hresp", 0), 32'(hresp[k]), 32'd0);
         chk(tg(k, "rst hrdata", 0), hrdata[k], 32'h0);
         chk(tg(k, "rst state", 0), 32'(dbg[k]), 32'(ST_IDLE));
      end
      for (int k = 0; k < 3; k++) hreset[k] = 1'b0;
      @(posedge hclk); #1;

      // Back-to-back word write then read
      tq.push_back(mk(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd2, 32'h0));
      run(0);

      // Byte and halfword lanes
      tq.push_back(mk(2'd2, 1'b1, 32'h13, 3'd0, 32'hAA000000));
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd2, 32'h0));
      tq.push_back(mk(2'd2, 1'b1, 32'h12, 3'd1, 32'h12340000));
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd2, 32'h0));
      run(0);

      // Two wait states, pipelined SEQ read
      tq.push_back(mk(2'd2, 1'b1, 32'h10, 3'd2, 32'hCAFEF00D));
      tq.push_back(mk(2'd3, 1'b1, 32'h14, 3'd2, 32'h0BADC0DE));
      run(1);
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd2, 32'h0));
      tq.push_back(mk(2'd3, 1'b0, 32'h14, 3'd2, 32'h0));
      run(1);

      // Out of range: two-cycle ERROR, no waits even with WAIT_STATES
      tq.push_back(mk(2'd2, 1'b0, 32'h400, 3'd2, 32'h0));
      run(0);
      tq.push_back(mk(2'd2, 1'b1, 32'h400, 3'd2, 32'h77777777));
      run(1);

      // Misaligned half write, bad size, IDLE/BUSY with HSEL
      tq.push_back(mk(2'd2, 1'b1, 32'h11, 3'd1, 32'hFFFFFFFF));
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd2, 32'h0));
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd3, 32'h0));
      tq.push_back(mk(2'd0, 1'b1, 32'h10, 3'd2, 32'h99999999));
      tq.push_back(mk(2'd1, 1'b1, 32'h10, 3'd2, 32'h88888888));
      tq.push_back(mk(2'd2, 1'b0, 32'h10, 3'd2, 32'h0));
      run(0);

      // Reset during the second wait of a write abandons it
      tq.push_back(mk(2'd2, 1'b1, 32'h20, 3'd2, 32'h11223344));
      run(2);
      drive_addr(2, mk(2'd2, 1'b1, 32'h20, 3'd2, 32'h55));
      @(posedge hclk); #1;
      hwdata[2] = 32'h55;
      drive_idle(2);
      chk("u2 wait1 hreadyout", 32'(hready_o[2]), 32'd0);
      @(posedge hclk); #1;
      chk("u2 wait2 hreadyout", 32'(hready_o[2]), 32'd0);
      hreset[2] = 1'b1;
      @(posedge hclk); #1;
      hreset[2] = 1'b0;
      chk("u2 post-rst hreadyout", 32'(hready_o[2]), 32'd1);
      chk("u2 post-rst hresp", 32'(hresp[2]), 32'd0);
      chk("u2 post-rst hrdata", hrdata[2], 32'h0);
      chk("u2 post-rst state", 32'(dbg[2]), 32'(ST_IDLE));
      tq.push_back(mk(2'd2, 1'b0, 32'h20, 3'd2, 32'h0));
      run(2);

      // Randomized traffic over a prefilled window
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            tq.push_back(mk(2'd2, 1'b1, 32'(4 * i), 3'd2, $urandom()));
         end
         run(k);
         rand_seq(60);
         run(k);
      end
      rand_seq(40);
      for (int i = 0; i < 16; i++) tq.push_front(mk(2'd2, 1'b1, 32'(4 * i), 3'd2, $urandom()));
      run(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
